// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Register map, window geometry and byte-enable mask helper
//               shared by the GPIO peripheral and its channels.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    typedef enum logic [2:0] {
        REG_OUT  = 3'd0,
        REG_DIR  = 3'd1,
        REG_IN   = 3'd2,
        REG_TGL  = 3'd3,
        REG_IE   = 3'd4,
        REG_IS   = 3'd5,
        REG_RSV6 = 3'd6,
        REG_RSV7 = 3'd7
    } gpio_reg_e;

    localparam int CH_STRIDE   = 32;
    localparam int WINDOW_BITS = 8;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_channel.sv
`default_nettype none
// ============================================================================
// Module      : gpio_channel
// Description : One GPIO channel: OUT/DIR registers, input synchroniser and
//               local read mux. Edge interrupts (IE/IS) only with GPIO_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_channel #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] OUT_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [2:0]       reg_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] wmask_i,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] pins_out_o,
    output logic [WIDTH-1:0] pins_oe_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             irq_o
);
    import gpio_pkg::*;

    gpio_reg_e        reg_sel;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] ie_rd, is_rd;

    assign reg_sel = gpio_reg_e'(reg_i);

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (we_i) begin
            case (reg_sel)
                REG_OUT: out_d = (out_q & ~wmask_i) | (wdata_i & wmask_i);
                REG_DIR: dir_d = (dir_q & ~wmask_i) | (wdata_i & wmask_i);
                REG_TGL: out_d = out_q ^ (wdata_i & wmask_i);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= OUT_RESET[WIDTH-1:0];
            dir_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            sync1_q <= pins_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] prev_q, ie_q, ie_d, is_q, is_d, rise, w1c;

    assign rise = sync2_q & ~prev_q;
    assign w1c  = (we_i && reg_sel == REG_IS) ? (wdata_i & wmask_i) : '0;
    assign ie_d = (we_i && reg_sel == REG_IE) ? ((ie_q & ~wmask_i) | (wdata_i & wmask_i)) : ie_q;
    // New edges are OR-ed in after the clear so a coincident edge is never lost.
    assign is_d = (is_q & ~w1c) | rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            ie_q   <= '0;
            is_q   <= '0;
        end else begin
            prev_q <= sync2_q;
            ie_q   <= ie_d;
            is_q   <= is_d;
        end
    end

    assign ie_rd = ie_q;
    assign is_rd = is_q;
    assign irq_o = |(is_q & ie_q);
`else
    assign ie_rd = '0;
    assign is_rd = '0;
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rdata_o = '0;
        case (reg_sel)
            REG_OUT: rdata_o = out_q;
            REG_DIR: rdata_o = dir_q;
            REG_IN:  rdata_o = sync2_q;
            REG_IE:  rdata_o = ie_rd;
            REG_IS:  rdata_o = is_rd;
            default: rdata_o = '0;
        endcase
    end

    assign pins_out_o = out_q;
    assign pins_oe_o  = dir_q;

endmodule
`default_nettype wire

// File: rtl/gpio_periph.sv
`default_nettype none
// ============================================================================
// Module      : gpio_periph
// Description : Memory-mapped multi-channel GPIO with registered reads.
//               Define GPIO_IRQ_EN to build the edge-interrupt logic.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_periph #(
    parameter int                CHANNELS  = 2,
    parameter int                WIDTH     = 8,
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 10'h300,
    parameter logic [31:0]       OUT_RESET = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         address,
    input  logic [31:0]               data_in,
    input  logic [3:0]                width,
    input  logic                      write,
    output logic [31:0]               data_out,
    input  logic [CHANNELS*WIDTH-1:0] pins_in,
    output logic [CHANNELS*WIDTH-1:0] pins_out,
    output logic [CHANNELS*WIDTH-1:0] pins_oe,
    output logic                      irq
);
    import gpio_pkg::*;

    logic              sel, ch_ok;
    logic [2:0]        ch, rsel;
    logic [31:0]       mask_full;
    logic [WIDTH-1:0]  wmask, wdata, rd_sel;
    logic [WIDTH-1:0]  ch_rdata [CHANNELS];
    logic [CHANNELS-1:0] ch_irq;
    logic [31:0]       data_d, data_q;
    logic              unused_bits;

    assign sel       = (address[ADDR_W-1:WINDOW_BITS] == BASE_ADDR[ADDR_W-1:WINDOW_BITS]);
    assign ch        = address[7:5];
    assign rsel      = address[4:2];
    assign ch_ok     = int'(ch) < CHANNELS;
    assign mask_full = be_to_mask(width);
    assign wmask     = mask_full[WIDTH-1:0];
    assign wdata     = data_in[WIDTH-1:0];
    assign unused_bits = ^{address[1:0], data_in, mask_full};

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        gpio_channel #(
            .WIDTH     (WIDTH),
            .OUT_RESET (OUT_RESET)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .we_i       (write && sel && (ch == 3'(c))),
            .reg_i      (rsel),
            .wdata_i    (wdata),
            .wmask_i    (wmask),
            .pins_i     (pins_in[c*WIDTH +: WIDTH]),
            .pins_out_o (pins_out[c*WIDTH +: WIDTH]),
            .pins_oe_o  (pins_oe[c*WIDTH +: WIDTH]),
            .rdata_o    (ch_rdata[c]),
            .irq_o      (ch_irq[c])
        );
    end

    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(ch) == c) rd_sel = ch_rdata[c];
        end
        data_d = (sel && ch_ok) ? 32'(rd_sel) : 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign data_out = data_q;
    assign irq      = |ch_irq;

endmodule
`default_nettype wire

// File: doc/gpio_periph.md
# gpio_periph

Parametrised memory-mapped general-purpose I/O peripheral on the CPU data bus, next to data memory. It succeeds the fixed 8-bit LED output port with CHANNELS independent channels of WIDTH bits each. Each channel has output, direction, synchronised input, toggle, and optional edge-triggered interrupt registers. Reads are registered, giving the same one-cycle read latency as the block RAMs, so the top-level read mux handles it like any other memory.

## Interface
- CHANNELS, 2, number of channels (1..8)
- WIDTH, 8, bits per channel (1..32)
- ADDR_W, 10, data address width
- BASE_ADDR, 10'h300, window base; only bits [ADDR_W-1:8] compared (256-byte window)
- OUT_RESET, 0, reset value of every OUT register (low WIDTH bits used)
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- address  in  ADDR_W  byte address from CPU data port
- data_in  in  32  write data
- width  in  4  byte enables; bit n enables data_in[8n+7:8n]
- write  in  1  write strobe
- data_out  out  32  registered read data
- pins_in  in  CHANNELS*WIDTH  external inputs (asynchronous); channel c at [c*WIDTH +: WIDTH]
- pins_out  out  CHANNELS*WIDTH  output values
- pins_oe  out  CHANNELS*WIDTH  output enables (1 = drive)
- irq  out  1  interrupt request

## Operation
- Select: sel = (address[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]). ch = address[7:5]. reg = address[4:2]. address[1:0] ignored.
- Per-channel registers:
  - 0x00 OUT: read/write.
  - 0x04 DIR: read/write.
  - 0x08 IN: read-only; synchronised pins.
  - 0x0C TGL: write-only; OUT ^= masked data; reads 0.
  - 0x10 IE: read/write; rising-edge interrupt enable.
  - 0x14 IS: status; write-1-to-clear.
  - 0x18, 0x1C: reserved.
- Write: takes effect when write && sel && ch < CHANNELS.
  - Effective mask = byte enables expanded to bits, truncated to WIDTH.
  - Unmasked bits are unchanged.
  - Writes to reserved registers, read-only registers, or ch ≥ CHANNELS are ignored.
- Read: each cycle, data_out <= (sel && ch < CHANNELS) ? zero-extended register : 0.
  - Reads are independent of write. A read of a register being written the same cycle returns the old value.
- pins_out = OUT; pins_oe = DIR. IN is valid regardless of DIR.
- Input path: two-flop synchroniser per bit, sync2. A third flop, prev, holds the previous sync2. rise = sync2 & ~prev.
- IS update: IS <= (IS & ~w1c_mask) | rise. If a clear and a new edge hit the same bit in the same cycle, set wins.
- IS latches edges even when IE = 0.
- irq = OR over all channels of |(IS & IE). It is combinational from flops and glitch-free.
- Reset: OUT = OUT_RESET, DIR = 0, IE = 0, IS = 0, sync/prev = 0, data_out = 0. Therefore pins_oe = 0 and irq = 0.
- Reset asserted mid-operation clears all state immediately. Write data is lost.
- Synchroniser reset to 0: a pin held high through reset produces one rise 3 cycles after reset release. This is accepted and documented.

## Timing
- Write to pins_out/pins_oe: visible one cycle after the write edge.
- Read: data_out valid one cycle after address is presented.
- pins_in change to IN readable: the value appears in sync2 after 2 edges. A read issued in the following cycle returns it.
- pins_in rising edge to IS bit set: 3 edges. With IE set, irq follows in the same cycle.
- W1C of IS to irq deassert: one cycle, unless a new edge arrives in that cycle.

## Configuration
- GPIO_IRQ_EN defined: the prev flops, IE, IS and the irq logic are present as above.
- GPIO_IRQ_EN undefined:
  - IE and IS read 0 and ignore writes.
  - irq tied 0.
  - prev flops and edge logic are removed.
  - The synchroniser remains.

## Structure
- Package gpio_pkg holds:
  - register offset constants (REG_OUT=0, REG_DIR=1, REG_IN=2, REG_TGL=3, REG_IE=4, REG_IS=5)
  - CH_STRIDE = 32 and WINDOW_BITS = 8
  - the byte-enable-to-bit-mask function
- Sub-module gpio_channel, one instance per channel, holds:
  - the OUT, DIR, IE and IS registers
  - the synchroniser and edge detect
  - a local read mux
- The top gpio_periph does address decode, selects the channel read data, registers data_out and ORs the irq terms.

## Test plan
- Reset with OUT_RESET=8'hA5 → pins_out ch0 = 8'hA5, pins_oe = 0, data_out = 0, irq = 0; read 0x304 → 0 one cycle later.
- Write 0x300 = 32'h1234_5678 with width=4'b0001 → ch0 OUT = 8'h78. Then write 0x30C = 8'hFF → OUT = 8'h87, read back 8'h87.
- Drive pins_in ch1 = 8'h3C → read 0x328 issued in the third cycle returns 8'h3C. A write to 0x328 leaves IN unchanged.
- GPIO_IRQ_EN: set ch1 IE = 8'h01 and raise pins_in bit 8 → IS[0] set and irq = 1 after 3 edges. W1C 0x334 = 1 → irq = 0 next cycle. Repeat with the W1C coinciding with a new edge → IS[0] stays 1.
- Access ch ≥ CHANNELS (0x340 with CHANNELS=2) and address 0x200 → writes ignored, reads 0, no state change.
- Assert reset mid-sequence after DIR = 8'hFF → pins_oe = 0 asynchronously, before the next clock edge.
